bus_sram_responder: RTL and testbench

BUS_SRAM_RESPONDER -- requirements
Module: bus_sram_responder

---
 rtl/bus_sram_responder_pkg.sv | 49 ++++
 rtl/bus_sram_array.sv | 31 +++
 rtl/bus_sram_responder.sv | 115 +++++++++++
 tb/tb_bus_sram_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sram_responder_pkg.sv
// Shared encodings and lane helpers for the bus SRAM responder.
package bus_sram_responder_pkg;

  typedef enum logic [1:0] {
    HB_BYTE = 2'b00,
    HB_HALF = 2'b01,
    HB_WORD = 2'b10,
    HB_RSVD = 2'b11
  } hb_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } state_e;

  // Byte enables for a write; misaligned halves/words are aligned down.
  function automatic logic [3:0] lane_enables(hb_e hb, logic [1:0] lane);
    case (hb)
      HB_BYTE: return 4'b0001 << lane;
      HB_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      HB_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(hb_e hb, logic [31:0] data);
    case (hb)
      HB_BYTE: return {4{data[7:0]}};
      HB_HALF: return {2{data[15:0]}};
      HB_WORD: return data;
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] lane_rdata(hb_e hb, logic [1:0] lane, logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (hb)
      HB_BYTE: return {{24{b[7]}}, b};
      HB_HALF: return {{16{h[15]}}, h};
      HB_WORD: return word;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/bus_sram_array.sv
// Word-organised storage with synchronous read and per-byte write enables.
module bus_sram_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o,
  input  logic [3:0]    wr_be_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (wr_be_i[i]) begin
        mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bus_sram_responder.sv
// Bus slave fronting a word SRAM window with programmable wait states.
module bus_sram_responder
  import bus_sram_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_BUS_ADDR,
  input  logic [31:0] i_BUS_WDATA,
  input  logic        i_BUS_WE,
  input  logic        i_BUS_RE,
  input  logic [1:0]  i_BUS_HB,
  input  logic        i_BUS_REQ,
  output logic        o_BUS_GNT,
  output logic [31:0] o_BUS_RDATA
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_START = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_END   = WIN_START + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  hb_e           hb_q;
  logic          we_q, re_q;
  logic [31:0]   wdata_q;

  logic          hit, accept, rd_en;
  logic [AW-1:0] live_idx, rd_idx;
  logic [31:0]   rd_word;
  logic [3:0]    wr_be;

  assign hit      = ({1'b0, i_BUS_ADDR} >= WIN_START) && ({1'b0, i_BUS_ADDR} < WIN_END);
  assign accept   = (state_q == ST_IDLE) && i_BUS_REQ && hit;
  assign live_idx = AW'((i_BUS_ADDR - BASE_ADDR) >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_ACK;
            rd_en   = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      hb_q    <= HB_BYTE;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= live_idx;
        lane_q  <= i_BUS_ADDR[1:0];
        hb_q    <= hb_e'(i_BUS_HB);
        we_q    <= i_BUS_WE;
        re_q    <= i_BUS_RE;
        wdata_q <= i_BUS_WDATA;
      end
    end
  end

  // Zero wait states read the live address in the accepting cycle; otherwise the latched one.
  assign rd_idx = (state_q == ST_IDLE) ? live_idx : idx_q;
  assign wr_be  = (state_q == ST_ACK && we_q) ? lane_enables(hb_q, lane_q) : 4'b0000;

  bus_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i    (i_clk),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_idx),
    .rd_data_o(rd_word),
    .wr_be_i  (wr_be),
    .wr_addr_i(idx_q),
    .wr_data_i(lane_wdata(hb_q, wdata_q))
  );

  assign o_BUS_GNT   = (state_q == ST_ACK);
  assign o_BUS_RDATA = (state_q == ST_ACK && re_q && !we_q) ? lane_rdata(hb_q, lane_q, rd_word) : '0;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Bench for bus_sram_responder: one instance with one wait state, one with none.
module tb_bus_sram_responder;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        we    [2];
  logic        re    [2];
  logic [1:0]  hb    [2];
  logic        req   [2];
  logic        gnt   [2];
  logic [31:0] rdata [2];

  logic [7:0]  mdl [2][4*DEPTH];
  int          n_cmp  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  bus_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_BUS_ADDR(addr[0]), .i_BUS_WDATA(wdata[0]),
    .i_BUS_WE(we[0]), .i_BUS_RE(re[0]), .i_BUS_HB(hb[0]), .i_BUS_REQ(req[0]),
    .o_BUS_GNT(gnt[0]), .o_BUS_RDATA(rdata[0]));

  bus_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_BUS_ADDR(addr[1]), .i_BUS_WDATA(wdata[1]),
    .i_BUS_WE(we[1]), .i_BUS_RE(re[1]), .i_BUS_HB(hb[1]), .i_BUS_REQ(req[1]),
    .o_BUS_GNT(gnt[1]), .o_BUS_RDATA(rdata[1]));

  // Byte-addressed little-endian memory model.
  function automatic int size_of(input logic [1:0] h);
    return (h == 2'd0) ? 1 : (h == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mdl_read(input int d, input int unsigned off, input int n);
    int unsigned b0;
    logic [31:0] v;
    b0 = off - (off % n);
    v  = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(mdl[d][b0 + k]) << (8 * k));
    if (n == 1 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
    if (n == 2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  task automatic mdl_write(input int d, input int unsigned off, input int n, input logic [31:0] wd);
    int unsigned b0;
    b0 = off - (off % n);
    for (int k = 0; k < n; k++) mdl[d][b0 + k] = 8'(wd >> (8 * k));
  endtask

  // One complete bus transaction; starts and ends at a falling edge with the DUT idle.
  task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic we_v, input logic re_v, input logic [1:0] hb_v,
                        input bit scr, input string tag, output logic [31:0] rd);
    int unsigned off;
    logic [31:0] exp_rd;
    bit got;
    int lat;
    off    = a - BASE;
    exp_rd = (re_v && !we_v && hb_v != 2'd3) ? mdl_read(d, off, size_of(hb_v)) : 32'h0;
    addr[d] = a; wdata[d] = wd; we[d] = we_v; re[d] = re_v; hb[d] = hb_v; req[d] = 1'b1;
    got = 0; lat = 0; rd = '0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); @(negedge clk);
      if (gnt[d] === 1'b1) begin
        got = 1; lat = c; rd = rdata[d];
      end else begin
        n_cmp++;
        if (rdata[d] !== 32'h0) begin
          n_fail++;
          $display("FAIL %s wait_rdata: got %h want 0", tag, rdata[d]);
        end
        if (scr) begin
          req[d] = 1'b0; addr[d] = $urandom; wdata[d] = $urandom;
          we[d] = 1'($urandom); re[d] = 1'($urandom); hb[d] = 2'($urandom);
        end
      end
    end
    req[d] = 1'b0;
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s grant_timeout: no grant within 40 cycles", tag);
    end else begin
      n_cmp++;
      if (lat != d + 1) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", tag, lat, d + 1);
      end
      n_cmp++;
      if (rd !== exp_rd) begin
        n_fail++;
        $display("FAIL %s rdata: got %h want %h", tag, rd, exp_rd);
      end
      if (we_v && hb_v != 2'd3) mdl_write(d, off, size_of(hb_v), wd);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (gnt[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s gnt_one_cycle: got %b want 0", tag, gnt[d]);
    end
  endtask

  task automatic test_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (gnt[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs%0d: got gnt=%b rdata=%h want 0/0", d, gnt[d], rdata[d]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_init();
    logic [31:0] rd;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++)
        access(d, BASE + 32'(4 * w), $urandom, 1'b1, 1'b0, 2'd2, 1'b0, "init", rd);
  endtask

  task automatic test_directed();
    logic [31:0] rd;
    access(1, BASE + 32'h10, 32'hDEAD_BEEF, 1, 0, 2'd2, 0, "dir_w", rd);
    access(1, BASE + 32'h10, 32'h0, 0, 1, 2'd2, 0, "dir_r", rd);
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dir_word: got %h want deadbeef", rd); end
    access(1, BASE + 32'h10, 32'h1122_3344, 1, 0, 2'd2, 0, "dir_w2", rd);
    access(1, BASE + 32'h13, 32'h0000_0080, 1, 0, 2'd0, 0, "dir_wb", rd);
    access(1, BASE + 32'h13, 32'h0, 0, 1, 2'd0, 0, "dir_rb", rd);
    n_cmp++;
    if (rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL dir_byte: got %h want ffffff80", rd); end
    access(1, BASE + 32'h10, 32'h0, 0, 1, 2'd2, 0, "dir_rw", rd);
    n_cmp++;
    if (rd !== 32'h8022_3344) begin n_fail++; $display("FAIL dir_merge: got %h want 80223344", rd); end
    access(1, BASE + 32'h22, 32'h0000_7FFE, 1, 0, 2'd1, 0, "dir_wh", rd);
    access(1, BASE + 32'h23, 32'h0, 0, 1, 2'd1, 0, "dir_rh", rd);
    n_cmp++;
    if (rd !== 32'h0000_7FFE) begin n_fail++; $display("FAIL dir_half: got %h want 00007ffe", rd); end
  endtask

  task automatic test_miss();
    logic [31:0] rd;
    logic [31:0] miss_a [2];
    int bad;
    miss_a[0] = BASE - 32'd4;
    miss_a[1] = BASE + 32'(4 * DEPTH);
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        addr[d] = miss_a[m]; wdata[d] = $urandom; we[d] = 1'b1; re[d] = 1'b0;
        hb[d] = 2'd2; req[d] = 1'b1;
        bad = 0;
        repeat (20) begin
          @(posedge clk); @(negedge clk);
          if (gnt[d] !== 1'b0 || rdata[d] !== 32'h0) bad++;
        end
        req[d] = 1'b0;
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL miss%0d_%0d: bad cycles %0d want 0", d, m, bad); end
      end
      access(d, BASE, 32'h0, 0, 1, 2'd2, 0, "miss_first", rd);
      access(d, BASE + 32'(4 * DEPTH - 4), 32'h0, 0, 1, 2'd2, 0, "miss_last", rd);
    end
  endtask

  task automatic test_special();
    logic [31:0] rd;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      a = BASE + 32'h80;
      access(d, a, 32'h1357_9BDF, 1, 0, 2'd2, 0, "sp_seed", rd);
      access(d, a, $urandom, 1, 0, 2'd3, 0, "sp_rsvd_w", rd);
      access(d, a, 32'h0, 0, 1, 2'd3, 0, "sp_rsvd_r", rd);
      access(d, a, 32'hCAFE_F00D, 1, 1, 2'd2, 0, "sp_both", rd);
      access(d, a, $urandom, 0, 0, 2'd2, 0, "sp_none", rd);
      access(d, a, 32'h0, 0, 1, 2'd2, 0, "sp_check", rd);
      n_cmp++;
      if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL sp_final%0d: got %h want cafef00d", d, rd); end
    end
  endtask

  // phase 1 resets during WAIT, phase 2 during ACK of a write.
  task automatic test_reset_abort(input int phase);
    logic [31:0] rd;
    logic [31:0] a;
    int bad;
    a = BASE + 32'h40;
    access(1, a, 32'h0, 1, 0, 2'd2, 0, "ra_clear", rd);
    addr[1] = a; wdata[1] = 32'hA5A5_A5A5; we[1] = 1'b1; re[1] = 1'b0; hb[1] = 2'd2; req[1] = 1'b1;
    repeat (phase) begin @(posedge clk); @(negedge clk); end
    n_cmp++;
    if (gnt[1] !== (phase == 2)) begin
      n_fail++; $display("FAIL reset_abort%0d_phase: got gnt=%b want %b", phase, gnt[1], phase == 2);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt[1] !== 1'b0 || rdata[1] !== 32'h0) begin
      n_fail++; $display("FAIL reset_abort%0d_force: got gnt=%b rdata=%h want 0/0", phase, gnt[1], rdata[1]);
    end
    req[1] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (gnt[1] !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_abort%0d_nognt: got %0d grants want 0", phase, bad); end
    access(1, a, 32'h0, 0, 1, 2'd2, 0, "ra_read", rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_abort%0d_data: got %h want 0", phase, rd); end
  endtask

  task automatic test_back_to_back();
    int unsigned w;
    logic [31:0] exp_rd;
    logic exp_g;
    w = $urandom_range(0, DEPTH - 1);
    exp_rd = mdl_read(0, 4 * w, 4);
    addr[0] = BASE + 32'(4 * w); wdata[0] = '0; we[0] = 1'b0; re[0] = 1'b1; hb[0] = 2'd2; req[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      exp_g = (i % 2 == 0);
      n_cmp++;
      if (gnt[0] !== exp_g || rdata[0] !== (exp_g ? exp_rd : 32'h0)) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got gnt=%b rdata=%h want %b/%h", i, gnt[0], rdata[0], exp_g,
                 exp_g ? exp_rd : 32'h0);
      end
    end
    req[0] = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] a;
    logic [1:0] h;
    int op, d;
    for (int i = 0; i < 160; i++) begin
      d  = i % 2;
      a  = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      h  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      op = $urandom_range(0, 5);
      case (op)
        0, 1:    access(d, a, $urandom, 0, 1, h, 1'($urandom), "rnd_rd", rd);
        2, 3:    access(d, a, $urandom, 1, 0, h, 1'($urandom), "rnd_wr", rd);
        4:       access(d, a, $urandom, 1, 1, h, 1'($urandom), "rnd_both", rd);
        default: access(d, a, $urandom, 0, 0, h, 1'($urandom), "rnd_none", rd);
      endcase
      if (op == 2 || op == 3)
        access(d, a, $urandom, 0, 1, h, 1'b0, "rnd_raw", rd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0; we[d] = 1'b0; re[d] = 1'b0; hb[d] = 2'd0; req[d] = 1'b0;
    end
    test_reset();
    test_init();
    test_directed();
    test_miss();
    test_special();
    test_reset_abort(1);
    test_reset_abort(2);
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
